// File: rtl/four_bit_comparator.sv
// ---------------------------------------------------------------------------
// four_bit_comparator
//   Registered unsigned magnitude comparator for two WIDTH-bit operands.
//   Produces one-hot greater/equal/less flags one clock after an accepted
//   operand pair. The flags hold their last value while in_valid is low.
//
// Optional feature (compile-time macro FOUR_BIT_COMPARATOR_DIFF_EN):
//   When defined, adds output diff carrying the registered |a-b|.
//   It has the same latency and hold behaviour as the flags.
//
// Parameters:
//   WIDTH      operand width in bits (1..32), default 4
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   a/b are sampled on this edge when high
//   a, b       unsigned operands
//   k          registered flag, a >  b
//   l          registered flag, a == b
//   m          registered flag, a <  b
//   out_valid  high for one cycle after each accepted pair
//   diff       registered |a-b| (only with FOUR_BIT_COMPARATOR_DIFF_EN)
// ---------------------------------------------------------------------------
module four_bit_comparator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             k,
    output logic             l,
    output logic             m,
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
    output logic [WIDTH-1:0] diff,
`endif
    output logic             out_valid
);

    // MSB-first magnitude compare: the first differing bit from the top
    // decides the ordering; if no bit differs the operands are equal.
    logic gt_c;
    logic lt_c;
    logic eq_c;

    always_comb begin
        gt_c = 1'b0;
        lt_c = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!gt_c && !lt_c && (a[i] != b[i])) begin
                gt_c = a[i];
                lt_c = b[i];
            end
        end
        eq_c = !gt_c && !lt_c;
    end

`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
    // Absolute difference; subtract the smaller from the larger so the
    // result never wraps.
    logic [WIDTH-1:0] diff_c;

    always_comb begin
        diff_c = '0;
        if (gt_c) begin
            diff_c = a - b;
        end else if (lt_c) begin
            diff_c = b - a;
        end
    end
`endif

    // Result registers: reset wins over in_valid; flags hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= 1'b0;
            l         <= 1'b0;
            m         <= 1'b0;
            out_valid <= 1'b0;
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
            diff      <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                k <= gt_c;
                l <= eq_c;
                m <= lt_c;
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
                diff <= diff_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_four_bit_comparator.sv
// ---------------------------------------------------------------------------
// tb_four_bit_comparator
//   Directed-vector bench for four_bit_comparator (WIDTH = 4). Inputs are
//   driven 1 time unit after a rising edge and outputs are sampled at the
//   same point after the following edge. Covers reset, single compare,
//   back-to-back streaming, extremes, hold with in_valid low, and reset
//   colliding with a valid pair. Checks diff when
//   FOUR_BIT_COMPARATOR_DIFF_EN is defined.
// ---------------------------------------------------------------------------
module tb_four_bit_comparator;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             k;
    logic             l;
    logic             m;
    logic             out_valid;
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
    logic [WIDTH-1:0] diff;
`endif

    int vectors_applied;
    int miscompares;

    four_bit_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .k         (k),
        .l         (l),
        .m         (m),
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
        .diff      (diff),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks {k,l,m}, out_valid and (when present) diff.
    task automatic check_out(input string tag, input logic [2:0] exp_klm,
                             input logic exp_ov, input logic [WIDTH-1:0] exp_diff);
        check({tag, ".klm"}, 32'({k, l, m}), 32'(exp_klm));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
`ifdef FOUR_BIT_COMPARATOR_DIFF_EN
        check({tag, ".diff"}, 32'(diff), 32'(exp_diff));
`else
        if (exp_diff != exp_diff) $display("unreachable");
`endif
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streaming vectors: a, b, expected {k,l,m}, expected diff.
    logic [WIDTH-1:0] s_a   [5] = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1011};
    logic [WIDTH-1:0] s_b   [5] = '{4'b1010, 4'b1101, 4'b1101, 4'b1111, 4'b1011};
    logic [2:0]       s_klm [5] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010};
    logic [WIDTH-1:0] s_dif [5] = '{4'd3, 4'd0, 4'd2, 4'd4, 4'd0};

    // Extremes.
    logic [WIDTH-1:0] x_a   [3] = '{4'b0000, 4'b1111, 4'b0000};
    logic [WIDTH-1:0] x_b   [3] = '{4'b0000, 4'b0000, 4'b1111};
    logic [2:0]       x_klm [3] = '{3'b010, 3'b100, 3'b001};
    logic [WIDTH-1:0] x_dif [3] = '{4'd0, 4'd15, 4'd15};

    initial begin
        vectors_applied = 0;
        miscompares     = 0;

        // Reset held for two edges with a valid pair presented.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'b1100;
        b        = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out($sformatf("reset%0d", i), 3'b000, 1'b0, 4'd0);
        end

        // First compare after reset release.
        rst = 1'b0;
        step();
        check_out("first", 3'b100, 1'b1, 4'd2);

        // Back-to-back streaming, out_valid must stay high.
        for (int i = 0; i < 5; i++) begin
            a = s_a[i];
            b = s_b[i];
            step();
            check_out($sformatf("stream%0d", i), s_klm[i], 1'b1, s_dif[i]);
        end

        // Extremes.
        for (int i = 0; i < 3; i++) begin
            a = x_a[i];
            b = x_b[i];
            step();
            check_out($sformatf("extreme%0d", i), x_klm[i], 1'b1, x_dif[i]);
        end

        // Hold: result stays while in_valid is low and operands toggle.
        a = 4'b1101;
        b = 4'b1010;
        step();
        check_out("hold_load", 3'b100, 1'b1, 4'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = ~a;
            b = b + 4'd5;
            step();
            check_out($sformatf("hold%0d", i), 3'b100, 1'b0, 4'd3);
        end

        // Reset on the same edge as a valid pair: the pair is discarded.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'b0001;
        b        = 4'b0010;
        step();
        check_out("rst_collide", 3'b000, 1'b0, 4'd0);

        // Next accepted pair is handled normally, then a single-cycle pulse.
        rst = 1'b0;
        a   = 4'b0010;
        b   = 4'b0001;
        step();
        check_out("post_rst", 3'b100, 1'b1, 4'd1);
        in_valid = 1'b0;
        step();
        check_out("post_rst_idle", 3'b100, 1'b0, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
